mkio_tx_arbiter: RTL and testbench

MKIO_TX_ARBITER -- requirements
Module: mkio_tx_arbiter

---
 rtl/mkio_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mkio_tx_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mkio_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a shared MIL-STD-1553-style
// word transmitter: status word after a response gap, then N data words.
module mkio_tx_arbiter #(
    parameter logic [4:0] ADDRESS = 5'd1,
    parameter logic [7:0] GAP     = 8'd40,
    parameter logic [7:0] TMO     = 8'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [11:0] req_len,
    input  logic [10:0] status_flags,
    output logic [1:0]  rd_strobe,
    input  logic [31:0] rd_data,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        err,
    output logic        busy,
    output logic        tx_ready,
    output logic [15:0] tx_data,
    output logic        tx_cd,
    input  logic        tx_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_SEND,
        S_WAIT_ACC,
        S_WAIT_END,
        S_FETCH,
        S_CAPTURE
    } state_t;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [1:0]  done_q;
    logic [1:0]  rd_strobe_q;
    logic        err_q;
    logic        busy_q;
    logic        tx_ready_q;
    logic        tx_cd_q;
    logic [15:0] tx_data_q;
    logic        ptr_q;
    logic [10:0] flags_q;
    logic [5:0]  cnt_q;
    logic [7:0]  gap_q;
    logic [7:0]  tmo_q;

    logic        win_d;
    logic [5:0]  len_d;
    logic [15:0] word_d;
    logic        tmo_hit_d;

    // Round-robin pick: the pointer names the requester with priority.
    always_comb begin
        win_d = ptr_q;
        if (!req[ptr_q]) begin
            win_d = ~ptr_q;
        end
        len_d     = win_d ? req_len[11:6] : req_len[5:0];
        word_d    = grant_q[1] ? rd_data[31:16] : rd_data[15:0];
        tmo_hit_d = ({1'b0, tmo_q} + 9'd1) >= {1'b0, TMO};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            done_q      <= 2'b00;
            rd_strobe_q <= 2'b00;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            tx_cd_q     <= 1'b0;
            tx_data_q   <= 16'h0000;
            ptr_q       <= 1'b0;
            flags_q     <= 11'h000;
            cnt_q       <= 6'd0;
            gap_q       <= 8'd0;
            tmo_q       <= 8'd0;
        end else begin
            done_q      <= 2'b00;
            err_q       <= 1'b0;
            tx_ready_q  <= 1'b0;
            rd_strobe_q <= 2'b00;

            case (state_q)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        grant_q <= win_d ? 2'b10 : 2'b01;
                        flags_q <= status_flags;
                        cnt_q   <= (len_d == 6'd0) ? 6'd32 : len_d;
                        // GAP-1 cycles here plus one in SEND puts tx_ready GAP cycles after grant.
                        gap_q   <= (GAP > 8'd1) ? (GAP - 8'd1) : 8'd1;
                        busy_q  <= 1'b1;
                        state_q <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (gap_q <= 8'd1) begin
                        tx_data_q <= {ADDRESS, flags_q};
                        tx_cd_q   <= 1'b0;
                        state_q   <= S_SEND;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end

                S_SEND: begin
                    if (!tx_busy) begin
                        tx_ready_q <= 1'b1;
                        tmo_q      <= 8'd0;
                        state_q    <= S_WAIT_ACC;
                    end
                end

                S_WAIT_ACC: begin
                    if (tx_busy) begin
                        state_q <= S_WAIT_END;
                    end else if (tmo_hit_d) begin
                        err_q   <= 1'b1;
                        grant_q <= 2'b00;
                        ptr_q   <= grant_q[0];
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end

                S_WAIT_END: begin
                    if (!tx_busy) begin
                        if (cnt_q != 6'd0) begin
                            rd_strobe_q <= grant_q;
                            state_q     <= S_FETCH;
                        end else begin
                            done_q  <= grant_q;
                            grant_q <= 2'b00;
                            ptr_q   <= grant_q[0];
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end

                // Strobe is high during FETCH; the requester answers in the following cycle.
                S_FETCH: begin
                    state_q <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    tx_data_q <= word_d;
                    tx_cd_q   <= 1'b1;
                    if (cnt_q != 6'd0) begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                    state_q <= S_SEND;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign rd_strobe = rd_strobe_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign tx_ready  = tx_ready_q;
    assign tx_data   = tx_data_q;
    assign tx_cd     = tx_cd_q;

endmodule

// File: tb/tb_mkio_tx_arbiter.sv
// Directed bench for mkio_tx_arbiter with a transmitter model and a
// registered-read requester model; expectations are hand-computed.
module tb_mkio_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [11:0] req_len = 12'd0;
    logic [10:0] status_flags = 11'd0;
    logic [31:0] rd_data = 32'hDEAD_DEAD;
    logic        tx_busy = 1'b0;
    logic [1:0]  rd_strobe, grant, done;
    logic        err, busy, tx_ready, tx_cd;
    logic [15:0] tx_data;

    int nvec = 0;
    int nerr = 0;

    int busy_len = 20;
    bit xmit_en = 1'b1;
    int bcnt = 0;
    int c0 = 0, c1 = 0;
    bit p0 = 1'b0, p1 = 1'b0;

    logic [15:0] wlog [0:511];
    logic        clog [0:511];
    logic [1:0]  glog [0:63];
    int nw = 0, ns = 0, nd = 0, ne = 0, ng = 0;
    logic [1:0] gprev = 2'b00;

    mkio_tx_arbiter #(.ADDRESS(5'd1), .GAP(8'd40), .TMO(8'd16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len),
        .status_flags(status_flags), .rd_strobe(rd_strobe), .rd_data(rd_data),
        .grant(grant), .done(done), .err(err), .busy(busy), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_cd(tx_cd), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // Transmitter: goes busy for busy_len cycles after accepting a word.
    always @(negedge clk) begin
        if (reset) bcnt = 0;
        else if (tx_ready && xmit_en) bcnt = busy_len;
        else if (bcnt != 0) bcnt = bcnt - 1;
        tx_busy = (bcnt != 0);
    end

    // Requesters: data valid only in the cycle after the strobe.
    always @(negedge clk) begin
        if (reset) begin
            c0 = 0; c1 = 0; p0 = 1'b0; p1 = 1'b0;
            rd_data = 32'hDEAD_DEAD;
        end else begin
            rd_data = 32'hDEAD_DEAD;
            if (p0) begin rd_data[15:0]  = 16'hA000 + c0[15:0]; c0 = c0 + 1; end
            if (p1) begin rd_data[31:16] = 16'hB000 + c1[15:0]; c1 = c1 + 1; end
            p0 = rd_strobe[0];
            p1 = rd_strobe[1];
        end
    end

    always @(negedge clk) begin
        if (tx_ready) begin
            if (nw < 512) begin wlog[nw] = tx_data; clog[nw] = tx_cd; end
            nw = nw + 1;
        end
        if (rd_strobe != 2'b00) ns = ns + 1;
        if (done != 2'b00) nd = nd + 1;
        if (err) ne = ne + 1;
        if (grant != 2'b00 && gprev == 2'b00) begin
            if (ng < 64) glog[ng] = grant;
            ng = ng + 1;
        end
        gprev = grant;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 2'b00;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 2'b00;
        tick(); tick();
        nvec++;
        if ({grant, done, err, busy, tx_ready, rd_strobe, tx_cd} !== 9'd0) begin
            nerr++; $display("FAIL reset_ctrl: got %b required 0", {grant, done, err, busy, tx_ready, rd_strobe, tx_cd});
        end
        nvec++;
        if (tx_data !== 16'h0000) begin nerr++; $display("FAIL reset_txdata: got %h required 0000", tx_data); end
        reset = 1'b0;
        tick(); tick();
        nvec++;
        if (busy !== 1'b0 || grant !== 2'b00) begin
            nerr++; $display("FAIL idle_no_req: busy %b grant %b required 0 00", busy, grant);
        end
    endtask

    task automatic test_single();
        int b, bs, bd, be, t;
        do_reset();
        b = nw; bs = ns; bd = nd; be = ne;
        xmit_en = 1'b1; busy_len = 20;
        req_len = 12'd2; status_flags = 11'd0; req = 2'b01;
        t = 0;
        while (grant == 2'b00 && t < 10) begin tick(); t++; end
        nvec++;
        if (grant !== 2'b01) begin nerr++; $display("FAIL single_grant: got %b required 01", grant); end
        req = 2'b00;
        nvec++;
        if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy: got %b required 1", busy); end
        t = 0;
        while (!tx_ready && t < 200) begin tick(); t++; end
        nvec++;
        if (t !== 40) begin nerr++; $display("FAIL gap_latency: got %0d required 40", t); end
        t = 0;
        while (done == 2'b00 && t < 1000) begin tick(); t++; end
        nvec++;
        if (done !== 2'b01) begin nerr++; $display("FAIL single_done: got %b required 01", done); end
        nvec++;
        if (grant !== 2'b00) begin nerr++; $display("FAIL single_grant_clr: got %b required 00", grant); end
        nvec++;
        if (nw - b !== 3) begin nerr++; $display("FAIL single_nwords: got %0d required 3", nw - b); end
        nvec++;
        if ({clog[b], wlog[b]} !== {1'b0, 16'h0800}) begin
            nerr++; $display("FAIL status_word: got cd %b %h required cd 0 0800", clog[b], wlog[b]);
        end
        nvec++;
        if ({clog[b+1], wlog[b+1]} !== {1'b1, 16'hA000}) begin
            nerr++; $display("FAIL data_word1: got cd %b %h required cd 1 A000", clog[b+1], wlog[b+1]);
        end
        nvec++;
        if ({clog[b+2], wlog[b+2]} !== {1'b1, 16'hA001}) begin
            nerr++; $display("FAIL data_word2: got cd %b %h required cd 1 A001", clog[b+2], wlog[b+2]);
        end
        nvec++;
        if (ns - bs !== 2) begin nerr++; $display("FAIL single_strobes: got %0d required 2", ns - bs); end
        nvec++;
        if (ne - be !== 0) begin nerr++; $display("FAIL single_err: got %0d required 0", ne - be); end
        tick();
        nvec++;
        if (done !== 2'b00 || nd - bd !== 1) begin
            nerr++; $display("FAIL done_pulse: done %b count %0d required 00 1", done, nd - bd);
        end
        nvec++;
        if ({tx_cd, tx_data} !== {1'b1, 16'hA001}) begin
            nerr++; $display("FAIL tx_hold: got cd %b %h required cd 1 A001", tx_cd, tx_data);
        end
    endtask

    task automatic test_round_robin();
        int gb, k, t;
        do_reset();
        gb = ng;
        busy_len = 4; xmit_en = 1'b1;
        req_len = {6'd1, 6'd1}; req = 2'b11;
        k = 0; t = 0;
        while (k < 3 && t < 3000) begin
            tick(); t++;
            if (done != 2'b00) begin
                k++;
                nvec++;
                if (grant !== 2'b00) begin nerr++; $display("FAIL rr_grant_at_done: got %b required 00", grant); end
            end
        end
        req = 2'b00;
        nvec++;
        if (k !== 3) begin nerr++; $display("FAIL rr_messages: got %0d required 3", k); end
        nvec++;
        if (glog[gb] !== 2'b01) begin nerr++; $display("FAIL rr_grant1: got %b required 01", glog[gb]); end
        nvec++;
        if (glog[gb+1] !== 2'b10) begin nerr++; $display("FAIL rr_grant2: got %b required 10", glog[gb+1]); end
        nvec++;
        if (glog[gb+2] !== 2'b01) begin nerr++; $display("FAIL rr_grant3: got %b required 01", glog[gb+2]); end
        tick(); tick(); tick();
        nvec++;
        if (grant !== 2'b00 || ng - gb !== 3) begin
            nerr++; $display("FAIL rr_after_drop: grant %b grants %0d required 00 3", grant, ng - gb);
        end
    endtask

    task automatic test_len32();
        int b, bs, t;
        do_reset();
        b = nw; bs = ns;
        busy_len = 3; xmit_en = 1'b1;
        req_len = {6'd0, 6'd5}; status_flags = 11'h5A5; req = 2'b10;
        t = 0;
        while (grant == 2'b00 && t < 10) begin tick(); t++; end
        nvec++;
        if (grant !== 2'b10) begin nerr++; $display("FAIL len32_grant: got %b required 10", grant); end
        req = 2'b00;
        t = 0;
        while (done == 2'b00 && t < 5000) begin tick(); t++; end
        nvec++;
        if (done !== 2'b10) begin nerr++; $display("FAIL len32_done: got %b required 10", done); end
        nvec++;
        if (ns - bs !== 32) begin nerr++; $display("FAIL len32_strobes: got %0d required 32", ns - bs); end
        nvec++;
        if (nw - b !== 33) begin nerr++; $display("FAIL len32_tx_ready: got %0d required 33", nw - b); end
        nvec++;
        if ({clog[b], wlog[b]} !== {1'b0, 16'h0DA5}) begin
            nerr++; $display("FAIL len32_status: got cd %b %h required cd 0 0DA5", clog[b], wlog[b]);
        end
        nvec++;
        if ({clog[b+1], wlog[b+1]} !== {1'b1, 16'hB000}) begin
            nerr++; $display("FAIL len32_first: got cd %b %h required cd 1 B000", clog[b+1], wlog[b+1]);
        end
        nvec++;
        if ({clog[b+32], wlog[b+32]} !== {1'b1, 16'hB01F}) begin
            nerr++; $display("FAIL len32_last: got cd %b %h required cd 1 B01F", clog[b+32], wlog[b+32]);
        end
    endtask

    task automatic test_timeout();
        int bd, be, t;
        do_reset();
        bd = nd; be = ne;
        xmit_en = 1'b0;
        req_len = 12'd2; status_flags = 11'd0; req = 2'b01;
        t = 0;
        while (!tx_ready && t < 200) begin tick(); t++; end
        req = 2'b00;
        nvec++;
        if (tx_ready !== 1'b1) begin nerr++; $display("FAIL tmo_tx_ready: got %b required 1", tx_ready); end
        t = 0;
        while (!err && t < 100) begin tick(); t++; end
        nvec++;
        if (t !== 16) begin nerr++; $display("FAIL tmo_latency: got %0d required 16", t); end
        nvec++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            nerr++; $display("FAIL tmo_release: grant %b busy %b required 00 0", grant, busy);
        end
        tick();
        nvec++;
        if (err !== 1'b0 || ne - be !== 1 || nd - bd !== 0) begin
            nerr++; $display("FAIL tmo_pulse: err %b errs %0d dones %0d required 0 1 0", err, ne - be, nd - bd);
        end
        xmit_en = 1'b1; busy_len = 3;
        req_len = {6'd1, 6'd1}; req = 2'b11;
        t = 0;
        while (grant == 2'b00 && t < 10) begin tick(); t++; end
        nvec++;
        if (grant !== 2'b10) begin nerr++; $display("FAIL tmo_ptr_advance: got %b required 10", grant); end
        req = 2'b00;
        t = 0;
        while (done == 2'b00 && t < 1000) begin tick(); t++; end
        nvec++;
        if (done !== 2'b10) begin nerr++; $display("FAIL tmo_next_done: got %b required 10", done); end
    endtask

    task automatic test_reset_midmsg();
        int b, bd, t;
        do_reset();
        b = nw; bd = nd;
        xmit_en = 1'b1; busy_len = 10;
        req_len = 12'd4; status_flags = 11'd0; req = 2'b01;
        t = 0;
        while (grant == 2'b00 && t < 10) begin tick(); t++; end
        req = 2'b00;
        t = 0;
        while (nw - b < 4 && t < 1000) begin tick(); t++; end
        nvec++;
        if (nw - b !== 4) begin nerr++; $display("FAIL mid_reach_word3: got %0d required 4", nw - b); end
        tick(); tick();
        reset = 1'b1;
        #1;
        nvec++;
        if ({grant, done, err, busy, tx_ready, rd_strobe, tx_cd, tx_data} !== 25'd0) begin
            nerr++; $display("FAIL mid_reset_outputs: got %h required 0",
                             {grant, done, err, busy, tx_ready, rd_strobe, tx_cd, tx_data});
        end
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        nvec++;
        if (nd - bd !== 0 || busy !== 1'b0) begin
            nerr++; $display("FAIL mid_dropped: dones %0d busy %b required 0 0", nd - bd, busy);
        end
        b = nw;
        req_len = 12'd2; req = 2'b01;
        t = 0;
        while (grant == 2'b00 && t < 10) begin tick(); t++; end
        req = 2'b00;
        t = 0;
        while (done == 2'b00 && t < 1000) begin tick(); t++; end
        nvec++;
        if (done !== 2'b01) begin nerr++; $display("FAIL rerun_done: got %b required 01", done); end
        nvec++;
        if (nw - b !== 3 || {clog[b+1], wlog[b+1]} !== {1'b1, 16'hA000}) begin
            nerr++; $display("FAIL rerun_words: count %0d word1 %h required 3 A000", nw - b, wlog[b+1]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_len32();
        test_timeout();
        test_reset_midmsg();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
